rsp_s2_prep_delay_ctrl: RTL
===========================

// Module: rsp_s2_prep_delay_ctrl
// PURPOSE
//  Sample-domain programmable delay controller for the resampler stage-2 prep path.
//  - Owns a circular buffer of MAX_DEPTH samples and sequences its write/read pointers.
//  - Output sample n equals input sample n-D, where D is runtime-programmable.
//  - Adds valid/ready flow control, fill tracking, flush and reconfiguration.
// PARAMETERS
//  DATA_WIDTH  16  sample width in bits
//  MAX_DEPTH   64  buffer entries, power of 2, >=2; largest programmable delay
//  PTR_W       $clog2(MAX_DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk          in   1           single clock, all logic rising-edge
//  rst          in   1           synchronous active-high reset
//  i_cfg_depth  in   PTR_W+1     delay D in samples; sampled on i_cfg_load
//  i_cfg_load   in   1           load D, clear buffer state, enter FILL
//  i_flush      in   1           discard stored samples, keep current D
//  i_x0_vld     in   1           input sample valid
//  o_x0_rdy     out  1           input ready
//  i_x0         in   DATA_WIDTH  input sample
//  o_y0_vld     out  1           output sample valid
//  i_y0_rdy     in   1           downstream ready
//  o_y0         out  DATA_WIDTH  delayed sample (registered)
//  o_busy       out  1           1 in FILL or RUN
// BEHAVIOUR
//  Reset values: o_x0_rdy=0, o_y0_vld=0, o_y0=0, o_busy=0; D=0; pointers and fill_cnt=0; state IDLE.
//  Depth clamp: D = clamp(i_cfg_depth, 1, MAX_DEPTH).
//  Accept: transfer = i_x0_vld & o_x0_rdy. Each accept writes buf[wr_ptr], then wr_ptr++ mod MAX_DEPTH.
//  States:
//   - IDLE: o_x0_rdy=0. i_cfg_load -> FILL.
//   - FILL: o_x0_rdy=1; no output. Accepts increment fill_cnt. Accept with fill_cnt==D-1 -> RUN.
//   - RUN: o_x0_rdy = ~o_y0_vld | i_y0_rdy.
//     Each accept reads buf[(wr_ptr-D) mod MAX_DEPTH] in the same cycle.
//     Read-before-write when the addresses collide (D==MAX_DEPTH).
//     The read result is registered into o_y0, and o_y0_vld=1 the next cycle (latency 1 clk).
//  Output handshake:
//   - o_y0/o_y0_vld hold stable while o_y0_vld & ~i_y0_rdy.
//   - o_y0_vld clears after a handshake with no new accept.
//  Flush / reload (any of FILL or RUN):
//   - i_flush or i_cfg_load -> next cycle: fill_cnt=0, wr_ptr=0, o_y0_vld=0, state FILL.
//   - The pending output word is dropped. Input accepted in that same cycle is discarded.
//   - i_flush in IDLE is ignored.
//  Priority: rst > i_cfg_load > i_flush > accept.
//  Buffer contents are not cleared; the fill gating guarantees no stale reads.
//  rst mid-operation returns everything to reset values on the next edge; D returns to 0.
//  o_busy = (state != IDLE).
// CONFIGURATION
//  RSP_S2_PREP_DLY_STAT_EN defined:
//   - adds output o_drop_cnt[15:0]: saturating count of samples discarded by flush/reload.
//   - o_drop_cnt counts fill_cnt plus any valid pending output; it is cleared only by rst.
//  Undefined: the port and its counter do not exist.
// STRUCTURE
//  Package rsp_s2_prep_pkg holds:
//   - typedef enum logic[1:0] {DLY_IDLE, DLY_FILL, DLY_RUN} dly_state_t
//   - localparam DLY_STAT_W = 16
//  Sub-module rsp_s2_prep_dly_ram: simple dual-port, 1 write port, 1 sync read port, read-first.
//  The controller holds FSM, pointers, fill counter and output register.
// TESTING
//  1. rst, load D=3, stream 1..10 with i_y0_rdy=1.
//     -> o_y0 = 1..7, first valid the cycle after input 4 is accepted.
//  2. D=MAX_DEPTH=64, stream 0..199 -> o_y0[k] = k-64; verifies read-before-write at collision.
//  3. D=2 in RUN, hold i_y0_rdy=0 for 5 cycles.
//     -> o_x0_rdy=0, o_y0 stable, no sample lost; ready restores order.
//  4. D=4, 6 samples in, assert i_flush.
//     -> o_y0_vld=0 next cycle; next 4 inputs produce no output; 5th input yields the 1st post-flush input.
//  5. In RUN with D=5, load i_cfg_depth=0 -> D clamps to 1; the next input's successor outputs it.
//  6. STAT_EN: D=3, 5 samples in, flush with the output pending -> o_drop_cnt=4.
//     Then assert rst -> o_drop_cnt=0, state IDLE, o_x0_rdy=0.

Source files
------------

// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and constants for the resampler stage-2 prep delay controller.
// The drop statistic is compiled in only when RSP_S2_PREP_DLY_STAT_EN is defined.
package rsp_s2_prep_pkg;

    typedef enum logic [1:0] {
        DLY_IDLE = 2'd0,
        DLY_FILL = 2'd1,
        DLY_RUN  = 2'd2
    } dly_state_t;

    localparam int DLY_STAT_W = 16;

endpackage

// File: rtl/rsp_s2_prep_dly_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
// Read-first: a read and a write to the same address return the old contents.
module rsp_s2_prep_dly_ram #(
    parameter int  DATA_WIDTH = 16,
    parameter int  DEPTH      = 64,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value when re_i is low so the output stays stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rsp_s2_prep_delay_ctrl.sv
// Programmable sample delay (y[n] = x[n-D]) over a circular buffer with valid/ready flow control.
// Optional RSP_S2_PREP_DLY_STAT_EN adds o_drop_cnt, a saturating count of samples lost to flush/reload.
module rsp_s2_prep_delay_ctrl
    import rsp_s2_prep_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  MAX_DEPTH  = 64,
    localparam int PTR_W      = $clog2(MAX_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_W:0]        i_cfg_depth,
    input  logic                  i_cfg_load,
    input  logic                  i_flush,
    input  logic                  i_x0_vld,
    output logic                  o_x0_rdy,
    input  logic [DATA_WIDTH-1:0] i_x0,
    output logic                  o_y0_vld,
    input  logic                  i_y0_rdy,
    output logic [DATA_WIDTH-1:0] o_y0,
    output logic                  o_busy,
    output dly_state_t            o_dbg_state
`ifdef RSP_S2_PREP_DLY_STAT_EN
    ,
    output logic [DLY_STAT_W-1:0] o_drop_cnt
`endif
);

    // Handshake: a word moves on any rising edge where vld & rdy are both high; a producer
    // holding vld keeps its data stable until that edge, and rdy may depend on the other side.

    dly_state_t     state_q;
    logic [PTR_W:0] depth_q;
    logic [PTR_W:0] fill_cnt_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic           y_vld_q;
    logic           busy_q;

    logic [PTR_W:0]   depth_clamped;
    logic             x_acc;
    logic             wr_en;
    logic             rd_en;
    logic [PTR_W-1:0] rd_addr;

    always_comb begin
        depth_clamped = i_cfg_depth;
        if (i_cfg_depth == '0) begin
            depth_clamped = (PTR_W+1)'(1);
        end else if (i_cfg_depth > (PTR_W+1)'(MAX_DEPTH)) begin
            depth_clamped = (PTR_W+1)'(MAX_DEPTH);
        end
    end

    always_comb begin
        o_x0_rdy = 1'b0;
        case (state_q)
            DLY_FILL: o_x0_rdy = 1'b1;
            DLY_RUN:  o_x0_rdy = ~y_vld_q | i_y0_rdy;
            default:  o_x0_rdy = 1'b0;
        endcase
    end

    // A sample taken in a flush/reload cycle is consumed but never stored.
    assign x_acc   = i_x0_vld & o_x0_rdy;
    assign wr_en   = x_acc & ~i_cfg_load & ~i_flush;
    assign rd_en   = wr_en & (state_q == DLY_RUN);
    assign rd_addr = wr_ptr_q - depth_q[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DLY_IDLE;
            depth_q    <= '0;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
            y_vld_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (i_cfg_load) begin
            state_q    <= DLY_FILL;
            depth_q    <= depth_clamped;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
            y_vld_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else if (i_flush && state_q != DLY_IDLE) begin
            state_q    <= DLY_FILL;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
            y_vld_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                DLY_FILL: begin
                    if (x_acc) begin
                        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                        fill_cnt_q <= fill_cnt_q + (PTR_W+1)'(1);
                        if (fill_cnt_q == depth_q - (PTR_W+1)'(1)) begin
                            state_q <= DLY_RUN;
                        end
                    end
                end
                DLY_RUN: begin
                    // fill_cnt stays at D here: every accept writes one sample and reads one out.
                    if (x_acc) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        y_vld_q  <= 1'b1;
                    end else if (y_vld_q && i_y0_rdy) begin
                        y_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DLY_IDLE;
                end
            endcase
        end
    end

    rsp_s2_prep_dly_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_x0),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (o_y0)
    );

    assign o_y0_vld    = y_vld_q;
    assign o_busy      = busy_q;
    assign o_dbg_state = state_q;

`ifdef RSP_S2_PREP_DLY_STAT_EN
    logic [DLY_STAT_W-1:0] drop_cnt_q;
    logic [DLY_STAT_W:0]   drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + (DLY_STAT_W+1)'(fill_cnt_q) + (DLY_STAT_W+1)'(y_vld_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if ((i_cfg_load || i_flush) && state_q != DLY_IDLE) begin
            drop_cnt_q <= drop_sum[DLY_STAT_W] ? '1 : drop_sum[DLY_STAT_W-1:0];
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
